// File: rtl/fetch_pipe_ctrl_if.sv
// ============================================================================
// Module      : fetch_pipe_ctrl_if
// Description : Fetch-stage bundle between the hazard/branch/imem side and
//               the fetch pipeline controller (PC, IF/ID, status).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_pipe_ctrl_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
);
  // Requests and instruction data flowing into the fetch stage
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] imem_instr;

  // Fetch PC, IF/ID contents and status flowing out of the fetch stage
  logic [PC_W-1:0]    pc_out;
  logic [PC_W-1:0]    ifid_pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic               ifid_valid;
  logic               idex_bubble;
  logic [1:0]         fetch_state;
  logic               stall_timeout;

  // Hazard unit / EX stage / instruction memory side
  modport master (
    output stall, branch_taken, branch_target, imem_instr,
    input  pc_out, ifid_pc, ifid_instr, ifid_valid, idex_bubble,
           fetch_state, stall_timeout
  );

  // Fetch controller side
  modport slave (
    input  stall, branch_taken, branch_target, imem_instr,
    output pc_out, ifid_pc, ifid_instr, ifid_valid, idex_bubble,
           fetch_state, stall_timeout
  );
endinterface

`default_nettype wire

// File: rtl/fetch_pipe_ctrl.sv
// ============================================================================
// Module      : fetch_pipe_ctrl
// Description : Program counter and IF/ID pipeline register owner. Honours
//               load-use stalls (ignored against bubbles), EX-stage branch
//               redirects (branch has priority), and runs a stall watchdog.
//               Optional performance counters: define FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pipe_ctrl #(
  parameter int                  PC_W      = 64,
  parameter int                  INSTR_W   = 32,
  parameter logic [PC_W-1:0]     RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h00000013,
  parameter int unsigned         MAX_STALL = 15
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  fetch_pipe_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  // Watchdog compare value, truncated to the 4-bit counter width
  localparam logic [3:0] STALL_LIMIT = 4'(MAX_STALL);

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    ifid_pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic               ifid_valid;
  logic [3:0]         stall_cnt;
  logic               stall_timeout;
  logic               eff_stall;

  // A stall against a bubble is spurious, and a redirect discards it anyway
  assign eff_stall = bus.stall & ifid_valid & ~bus.branch_taken;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state: redirect beats stall; REDIRECT cannot reach HOLD since
  // IF/ID is a bubble there, which already masks eff_stall
  always_comb begin
    next_state = ST_RUN;
    if (bus.branch_taken) begin
      next_state = ST_REDIRECT;
    end else if (eff_stall) begin
      next_state = ST_HOLD;
    end
  end

  // FSM outputs and the combinational ID/EX bubble request
  always_comb begin
    bus.fetch_state = state;
    bus.idex_bubble = eff_stall | bus.branch_taken;
  end

  // PC and IF/ID register: flush on redirect, hold on stall, else advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (bus.branch_taken) begin
      pc         <= bus.branch_target;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (!eff_stall) begin
      pc         <= pc + PC_W'(4);
      ifid_pc    <= pc;
      ifid_instr <= bus.imem_instr;
      ifid_valid <= 1'b1;
    end
  end

  // Watchdog: saturating run-length of effective stalls, sticky trip flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt     <= 4'd0;
      stall_timeout <= 1'b0;
    end else if (eff_stall) begin
      if (stall_cnt == STALL_LIMIT) begin
        stall_timeout <= 1'b1;
      end
      if (stall_cnt != 4'hF) begin
        stall_cnt <= stall_cnt + 4'd1;
      end
    end else begin
      stall_cnt <= 4'd0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Free-running event counters, wrapping modulo 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (eff_stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (bus.branch_taken) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

  assign bus.pc_out        = pc;
  assign bus.ifid_pc       = ifid_pc;
  assign bus.ifid_instr    = ifid_instr;
  assign bus.ifid_valid    = ifid_valid;
  assign bus.stall_timeout = stall_timeout;

endmodule

`default_nettype wire

// File: doc/fetch_pipe_ctrl.md
Name: fetch_pipe_ctrl

Overview:
- Consumer end of the load-use hazard interface. Owns the program counter and the IF/ID pipeline register, and acts on the hazard unit's stall request and the EX-stage branch redirect.
- Sits between instruction memory and decode. Produces the fetch PC and the decode-stage instruction/PC, and suppresses spurious stalls raised against bubbles.

Parameters:
- PC_W, 64, width of PC and branch target.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) written on flush.
- MAX_STALL, 15, consecutive effective-stall cycles before the watchdog trips.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  load-use stall request from the hazard detection unit; 1 = hold PC and IF/ID.
- branch_taken  input  1  EX-stage redirect; 1 = flush IF/ID and load branch_target.
- branch_target  input  PC_W  redirect address, byte address.
- imem_instr  input  INSTR_W  instruction memory read data for pc_out; combinational, same cycle.
- pc_out  output  PC_W  current fetch PC.
- ifid_pc  output  PC_W  PC of the instruction in IF/ID.
- ifid_instr  output  INSTR_W  instruction in IF/ID.
- ifid_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
- idex_bubble  output  1  combinational; 1 = ID/EX must capture a bubble this cycle.
- fetch_state  output  2  FSM state: 0 RUN, 1 HOLD, 2 REDIRECT.
- stall_timeout  output  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, any cycle including mid-stall or mid-redirect) sets:
  - pc_out = RESET_PC, ifid_pc = 0, ifid_instr = NOP_INSTR, ifid_valid = 0.
  - fetch_state = RUN, stall counter = 0, stall_timeout = 0.
- Effective stall: eff_stall = stall & ifid_valid & ~branch_taken. A stall raised while IF/ID holds a bubble is ignored.
- Per-edge priority:
  1. branch_taken: pc_out <= branch_target; ifid_instr <= NOP_INSTR; ifid_valid <= 0; ifid_pc <= 0; state <= REDIRECT.
  2. eff_stall: pc_out, ifid_pc, ifid_instr and ifid_valid hold; state <= HOLD.
  3. otherwise: ifid_pc <= pc_out; ifid_instr <= imem_instr; ifid_valid <= 1; pc_out <= pc_out + 4; state <= RUN.
- Simultaneous branch_taken and stall: branch wins; stall is dropped.
- PC arithmetic is modulo 2^PC_W; wrap from all-ones-minus-3 to 0 is silent. branch_target bits [1:0] are used as given; no alignment check.
- idex_bubble = eff_stall | branch_taken. Combinational, no register.
- FSM:
  - RUN -> HOLD on eff_stall.
  - RUN or HOLD -> REDIRECT on branch_taken.
  - HOLD -> RUN when eff_stall drops.
  - REDIRECT -> RUN next cycle, unless branch_taken again (stays REDIRECT).
  - REDIRECT never enters HOLD, because ifid_valid = 0 there.
- Fetch latency: instruction at pc_out appears on ifid_instr one edge later, absent stall or branch. Branch penalty: 1 bubble in IF/ID, and ID/EX bubbled in the branch cycle.
- Watchdog:
  - A 4-bit saturating counter increments each cycle eff_stall = 1 and clears when eff_stall = 0.
  - When count == MAX_STALL with eff_stall still 1, stall_timeout <= 1.
  - stall_timeout is cleared only by reset.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_stall_cnt (32 bits): increments on every eff_stall cycle.
  - perf_flush_cnt (32 bits): increments on every branch_taken cycle.
  - Both reset to 0 asynchronously, wrap modulo 2^32, and are independent of the watchdog.
- When not defined, neither port nor their registers exist; all other behaviour is identical.

Test Plan:
- Reset release, imem_instr = 32'hA, stall = 0 for 3 cycles -> pc_out 0,4,8,12; ifid_pc 0,4,8; ifid_valid = 1 from the first edge; fetch_state = RUN.
- With ifid_valid = 1 and pc_out = 8, stall = 1 for 2 cycles -> pc_out stays 8, IF/ID unchanged, idex_bubble = 1 both cycles, fetch_state = HOLD; after release, ifid_pc = 8 next edge.
- branch_taken = 1 with target 0x100 and stall = 1 same cycle -> next edge pc_out = 0x100, ifid_instr = 0x00000013, ifid_valid = 0, fetch_state = REDIRECT; the following cycle with stall = 1 is ignored and pc_out = 0x104.
- stall held 20 cycles on a valid instruction -> stall_timeout rises after the 16th stalled edge and stays 1 after stall drops, until reset.
- Assert reset mid-HOLD and mid-REDIRECT -> all outputs return to reset values immediately, without waiting for a clock edge.
- Set pc_out near 2^PC_W-4, no stall -> next pc_out = 0. With FETCH_PERF_CNT_EN defined, 3 stalls plus 2 branches -> perf_stall_cnt = 3, perf_flush_cnt = 2.
